bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
- Sits directly upstream of the 4-digit seven-segment multiplexer.
- Its four BCD digit outputs drive that multiplexer's hex3..hex0 inputs; dp_out drives its dp_in.
- Converts a binary count (0..9999 displayable) on request, using a start/done handshake, and holds the result stable between conversions.

---
 rtl/bin2bcd_seq_if.sv | 27 ++
 rtl/bin2bcd_seq.sv | 129 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between the binary-to-BCD converter and its requester.
// The requester drives start/bin/dp_sel; the converter returns digits, dp pattern and status.
interface bin2bcd_seq_if #(
    parameter int W = 14
);
    logic         start;
    logic [W-1:0] bin;
    logic [3:0]   dp_sel;
    logic [3:0]   bcd3;
    logic [3:0]   bcd2;
    logic [3:0]   bcd1;
    logic [3:0]   bcd0;
    logic [3:0]   dp_out;
    logic         busy;
    logic         done;
    logic         ovf;

    modport master (
        output start, bin, dp_sel,
        input  bcd3, bcd2, bcd1, bcd0, dp_out, busy, done, ovf
    );

    modport slave (
        input  start, bin, dp_sel,
        output bcd3, bcd2, bcd1, bcd0, dp_out, busy, done, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock, feeding the 4-digit display mux.
// Optional macro BIN2BCD_SATURATE_EN: overflowing values (> 9999) display as 9999 instead of modulo 10000.
module bin2bcd_seq #(
    parameter int W = 14
) (
    input logic          clk,
    input logic          reset,
    bin2bcd_seq_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic           w_load;
    logic           w_shiftEn;
    logic           w_write;
    logic [19:0]    r_acc;
    logic [19:0]    w_accAdj;
    logic [W-1:0]   r_shift;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     r_dpLatch;
    logic [15:0]    r_bcd;
    logic [15:0]    w_bcdOut;
    logic [3:0]     r_dpOut;
    logic           r_ovf;
    logic           r_done;
    logic           w_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_shiftEn   = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                w_shiftEn = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_write     = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Digits of 5 or more get +3 before the shift so they carry correctly into the next decade.
    always_comb begin
        w_accAdj = r_acc;
        for (int d = 0; d < 5; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_accAdj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_ovf = |r_acc[19:16];

`ifdef BIN2BCD_SATURATE_EN
    assign w_bcdOut = w_ovf ? 16'h9999 : r_acc[15:0];
`else
    assign w_bcdOut = r_acc[15:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_dpLatch <= '0;
            r_bcd     <= '0;
            r_dpOut   <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_write;
            if (w_load) begin
                r_shift   <= bus.bin;
                r_dpLatch <= bus.dp_sel;
                r_acc     <= '0;
                r_cnt     <= CW'(W);
            end
            if (w_shiftEn) begin
                r_acc   <= (w_accAdj << 1) | 20'(r_shift[W-1]);
                r_shift <= r_shift << 1;
                r_cnt   <= r_cnt - CW'(1);
            end
            // Outputs change only here, so an aborted conversion never exposes a partial result.
            if (w_write) begin
                r_bcd   <= w_bcdOut;
                r_dpOut <= r_dpLatch;
                r_ovf   <= w_ovf;
            end
        end
    end

    assign bus.bcd3   = r_bcd[15:12];
    assign bus.bcd2   = r_bcd[11:8];
    assign bus.bcd1   = r_bcd[7:4];
    assign bus.bcd0   = r_bcd[3:0];
    assign bus.dp_out = r_dpOut;
    assign bus.ovf    = r_ovf;
    assign bus.done   = r_done;
    assign bus.busy   = (r_state != IDLE);
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (W=14) with hand-computed BCD results.
// Expected digits for overflowing input follow the BIN2BCD_SATURATE_EN setting.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   passCount  = 0;

    bin2bcd_seq_if #(.W(14)) bus ();

    bin2bcd_seq #(.W(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] digits();
        return {16'h0, bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Pulses start for one cycle; returns just after the accepting edge.
    task automatic applyStimulus(input logic [13:0] value, input logic [3:0] dp);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin    = value;
        bus.dp_sel = dp;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        int lat;
        int doneSeen;
        logic [31:0] gotDigits;
        logic gotOvf;

        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.bin    = '0;
        bus.dp_sel = '0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        doneSeen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkOutput("reset digits", digits(), 32'h0000);
        checkOutput("reset dp", 32'(bus.dp_out), 32'h0);
        checkOutput("reset busy", 32'(bus.busy), 32'h0);
        checkOutput("reset ovf", 32'(bus.ovf), 32'h0);
        checkOutput("reset no done", doneSeen, 0);

        applyStimulus(14'd0, 4'b0100);
        checkOutput("zero busy", 32'(bus.busy), 32'h1);
        waitDone(lat);
        checkOutput("zero latency", lat, 15);
        checkOutput("zero digits", digits(), 32'h0000);
        checkOutput("zero dp", 32'(bus.dp_out), 32'h4);
        checkOutput("zero ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk);
        checkOutput("zero done pulse", 32'(bus.done), 32'h0);
        checkOutput("zero idle", 32'(bus.busy), 32'h0);

        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin    = 14'd1234;
        bus.dp_sel = 4'b0001;
        @(negedge clk);
        bus.bin = 14'd9999;
        checkOutput("b2b busy", 32'(bus.busy), 32'h1);
        waitDone(lat);
        checkOutput("b2b first latency", lat, 15);
        checkOutput("b2b first digits", digits(), 32'h1234);
        checkOutput("b2b first ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("b2b reaccept", 32'(bus.busy), 32'h1);
        checkOutput("b2b done low", 32'(bus.done), 32'h0);
        waitDone(lat);
        checkOutput("b2b second latency", lat, 15);
        checkOutput("b2b second digits", digits(), 32'h9999);
        checkOutput("b2b second ovf", 32'(bus.ovf), 32'h0);

        applyStimulus(14'd12345, 4'b0010);
        waitDone(lat);
        checkOutput("ovf latency", lat, 15);
`ifdef BIN2BCD_SATURATE_EN
        checkOutput("ovf digits", digits(), 32'h9999);
`else
        checkOutput("ovf digits", digits(), 32'h2345);
`endif
        checkOutput("ovf flag", 32'(bus.ovf), 32'h1);
        checkOutput("ovf dp", 32'(bus.dp_out), 32'h2);

        applyStimulus(14'd42, 4'b0011);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'd7777;
        @(negedge clk);
        bus.start = 1'b0;
        doneSeen  = 0;
        gotDigits = '0;
        gotOvf    = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) begin
                doneSeen++;
                gotDigits = digits();
                gotOvf    = bus.ovf;
            end
        end
        checkOutput("busy-start single done", doneSeen, 1);
        checkOutput("busy-start digits", gotDigits, 32'h0042);
        checkOutput("busy-start ovf", 32'(gotOvf), 32'h0);
        checkOutput("busy-start dp", 32'(bus.dp_out), 32'h3);
        checkOutput("busy-start idle", 32'(bus.busy), 32'h0);

        applyStimulus(14'd5678, 4'b1000);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort digits", digits(), 32'h0000);
        checkOutput("abort dp", 32'(bus.dp_out), 32'h0);
        checkOutput("abort busy", 32'(bus.busy), 32'h0);
        doneSeen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkOutput("abort no done", doneSeen, 0);
        checkOutput("abort digits held", digits(), 32'h0000);

        applyStimulus(14'd5678, 4'b1000);
        waitDone(lat);
        checkOutput("rerun latency", lat, 15);
        checkOutput("rerun digits", digits(), 32'h5678);
        checkOutput("rerun dp", 32'(bus.dp_out), 32'h8);
        checkOutput("rerun ovf", 32'(bus.ovf), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
